rv32_dmem_bridge: RTL and testbench

- Sits directly downstream of the memory stage's data-memory port and consumes its single-cycle, combinational read/write/mask/address/value interface.
- Converts each access into a registered Wishbone-style classic bus cycle with cyc/stb/ack/err.
- Holds the pipeline through a stall request until the bus completes, then presents the read data for exactly the cycle in which the memory stage latches it.
- Includes a timeout watchdog and reports bus faults.

---
 rtl/rv32_dmem_bridge.sv | 150 +++++++++++++++
 tb/tb_rv32_dmem_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_dmem_bridge.sv
// rtl/rv32_dmem_bridge.sv - memory-stage data port to classic Wishbone-style bus bridge with stall, timeout and fault reporting
module rv32_dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        core_read_in,
    input  logic        core_write_in,
    input  logic [3:0]  core_write_mask_in,
    input  logic [31:0] core_address_in,
    input  logic [31:0] core_write_value_in,
    output logic [31:0] core_read_value_out,
    input  logic        pipe_stall_in,
    output logic        stall_out,
    output logic        fault_out,
    output logic        bus_cyc_out,
    output logic        bus_stb_out,
    output logic        bus_we_out,
    output logic [3:0]  bus_sel_out,
    output logic [29:0] bus_adr_out,
    output logic [31:0] bus_dat_out,
    input  logic [31:0] bus_dat_in,
    input  logic        bus_ack_in,
    input  logic        bus_err_in
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [29:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fault_q, fault_d;

    logic req;
    logic timeout;
    logic addr_lsb_unused;

    assign req             = core_read_in | core_write_in;
    assign addr_lsb_unused = ^core_address_in[1:0];

    // Timeout fires on the BUSY cycle whose edge brings the count up to TIMEOUT_CYCLES.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = core_write_in;
                    sel_d   = core_write_in ? core_write_mask_in : 4'b1111;
                    adr_d   = core_address_in[31:2];
                    dat_d   = core_write_value_in;
                    cnt_d   = '0;
                    rdata_d = '0;
                    fault_d = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (bus_err_in || timeout) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    rdata_d = '0;
                    fault_d = 1'b1;
                end else if (bus_ack_in) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : bus_dat_in;
                    fault_d = 1'b0;
                end
            end
            DONE: begin
                if (!pipe_stall_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign stall_out           = req & (state_q != DONE);
    assign core_read_value_out = (state_q == DONE) ? rdata_q : 32'd0;
    assign fault_out           = (state_q == DONE) & fault_q;
    assign bus_cyc_out         = cyc_q;
    assign bus_stb_out         = stb_q;
    assign bus_we_out          = we_q;
    assign bus_sel_out         = sel_q;
    assign bus_adr_out         = adr_q;
    assign bus_dat_out         = dat_q;

endmodule

// File: tb/tb_rv32_dmem_bridge.sv
// tb/tb_rv32_dmem_bridge.sv - self-checking bench for rv32_dmem_bridge
module tb_rv32_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_read_in, core_write_in;
    logic [3:0]  core_write_mask_in;
    logic [31:0] core_address_in, core_write_value_in;
    logic        pipe_stall_in;
    logic [31:0] bus_dat_in;
    logic        bus_ack_in, bus_err_in;

    logic [31:0] core_read_value_out;
    logic        stall_out, fault_out, bus_cyc_out, bus_stb_out, bus_we_out;
    logic [3:0]  bus_sel_out;
    logic [29:0] bus_adr_out;
    logic [31:0] bus_dat_out;

    logic [31:0] to_rdata;
    logic        to_stall, to_fault, to_cyc, to_stb, to_we;
    logic [3:0]  to_sel;
    logic [29:0] to_adr;
    logic [31:0] to_dat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_dmem_bridge dut (
        .clk(clk), .reset_n(reset_n),
        .core_read_in(core_read_in), .core_write_in(core_write_in),
        .core_write_mask_in(core_write_mask_in), .core_address_in(core_address_in),
        .core_write_value_in(core_write_value_in), .core_read_value_out(core_read_value_out),
        .pipe_stall_in(pipe_stall_in), .stall_out(stall_out), .fault_out(fault_out),
        .bus_cyc_out(bus_cyc_out), .bus_stb_out(bus_stb_out), .bus_we_out(bus_we_out),
        .bus_sel_out(bus_sel_out), .bus_adr_out(bus_adr_out), .bus_dat_out(bus_dat_out),
        .bus_dat_in(bus_dat_in), .bus_ack_in(bus_ack_in), .bus_err_in(bus_err_in)
    );

    rv32_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset_n(reset_n),
        .core_read_in(core_read_in), .core_write_in(core_write_in),
        .core_write_mask_in(core_write_mask_in), .core_address_in(core_address_in),
        .core_write_value_in(core_write_value_in), .core_read_value_out(to_rdata),
        .pipe_stall_in(pipe_stall_in), .stall_out(to_stall), .fault_out(to_fault),
        .bus_cyc_out(to_cyc), .bus_stb_out(to_stb), .bus_we_out(to_we),
        .bus_sel_out(to_sel), .bus_adr_out(to_adr), .bus_dat_out(to_dat),
        .bus_dat_in(bus_dat_in), .bus_ack_in(bus_ack_in), .bus_err_in(bus_err_in)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          waits;
        logic        ack;
        logic        err;
        int          hold;
        logic        chain;
        logic [3:0]  e_sel;
        logic [29:0] e_adr;
        logic        e_we;
        logic [31:0] e_rdata;
        logic        e_fault;
        int          e_stalls;
    } vec_t;

    vec_t vecs[8];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] mask,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] brd, input int waits, input logic ack,
                                input logic err, input int hold, input logic chain,
                                input logic [3:0] e_sel, input logic [29:0] e_adr,
                                input logic e_we, input logic [31:0] e_rdata,
                                input logic e_fault, input int e_stalls);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mask = mask; v.addr = addr; v.wdata = wdata; v.brd = brd;
        v.waits = waits; v.ack = ack; v.err = err; v.hold = hold; v.chain = chain;
        v.e_sel = e_sel; v.e_adr = e_adr; v.e_we = e_we; v.e_rdata = e_rdata;
        v.e_fault = e_fault; v.e_stalls = e_stalls;
        return v;
    endfunction

    // Called on a falling edge; returns on the falling edge of the IDLE cycle after DONE.
    task automatic run_access(input vec_t v);
        int   stalls = 0;
        int   busy   = 0;
        bit   done   = 0;
        vec_t e;
        core_read_in        = v.rd;
        core_write_in       = v.wr;
        core_write_mask_in  = v.mask;
        core_address_in     = v.addr;
        core_write_value_in = v.wdata;
        pipe_stall_in       = 1'b0;
        exp_q.push_back(v);
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            bus_ack_in = 1'b0;
            bus_err_in = 1'b0;
            bus_dat_in = 32'hA5A5_0F0F;
            if (stall_out) stalls++;
            if (bus_cyc_out) begin
                busy++;
                chk("busy_stb", 32'(bus_stb_out), 32'd1);
                chk("busy_adr", 32'(bus_adr_out), 32'(v.e_adr));
                chk("busy_sel", 32'(bus_sel_out), 32'(v.e_sel));
                chk("busy_we", 32'(bus_we_out), 32'(v.e_we));
                if (v.e_we) chk("busy_dat", bus_dat_out, v.wdata);
                if (busy == v.waits + 1) begin
                    bus_ack_in = v.ack;
                    bus_err_in = v.err;
                    bus_dat_in = v.brd;
                end
            end else if (!stall_out) begin
                done = 1;
                e = exp_q.pop_front();
                chk("done_rdata", core_read_value_out, e.e_rdata);
                chk("done_fault", 32'(fault_out), 32'(e.e_fault));
                chk("stall_cycles", 32'(stalls), 32'(e.e_stalls));
                if (e.hold > 0) begin
                    pipe_stall_in = 1'b1;
                    for (int h = 0; h < e.hold; h++) begin
                        @(negedge clk);
                        #1;
                        chk("hold_rdata", core_read_value_out, e.e_rdata);
                        chk("hold_stb", 32'(bus_stb_out), 32'd0);
                        chk("hold_stall", 32'(stall_out), 32'd0);
                        if (h == e.hold - 1) pipe_stall_in = 1'b0;
                    end
                end
            end
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL access_timeout: got no DONE expected DONE within 40 cycles");
        end
    endtask

    initial begin
        int  busy;
        bit  fin;

        vecs[0] = mk(1'b1, 1'b0, 4'h0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 0, 1'b0,
                     4'hF, 30'h401, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);
        vecs[1] = mk(1'b0, 1'b1, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h1111_2222, 3, 1'b1, 1'b0, 0, 1'b0,
                     4'b0100, 30'h800, 1'b1, 32'h0, 1'b0, 5);
        vecs[2] = mk(1'b1, 1'b0, 4'h0, 32'h3000_0010, 32'h0, 32'h1234_5678, 1, 1'b1, 1'b0, 0, 1'b0,
                     4'hF, 30'h0C00_0004, 1'b0, 32'h1234_5678, 1'b0, 3);
        vecs[3] = mk(1'b1, 1'b1, 4'b0011, 32'h0000_0040, 32'h0000_BEEF, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 0, 1'b0,
                     4'b0011, 30'h10, 1'b1, 32'h0, 1'b0, 2);
        vecs[4] = mk(1'b1, 1'b0, 4'h0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 2, 1'b0, 1'b1, 0, 1'b0,
                     4'hF, 30'h20, 1'b0, 32'h0, 1'b1, 4);
        vecs[5] = mk(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h55AA_55AA, 0, 1'b1, 1'b0, 3, 1'b0,
                     4'hF, 30'h40, 1'b0, 32'h55AA_55AA, 1'b0, 2);
        vecs[6] = mk(1'b1, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 32'h0BAD_F00D, 0, 1'b1, 1'b0, 0, 1'b1,
                     4'hF, 30'h3FFF_FFFF, 1'b0, 32'h0BAD_F00D, 1'b0, 2);
        vecs[7] = mk(1'b0, 1'b1, 4'hF, 32'h0000_0008, 32'h1357_9BDF, 32'h2468_ACE0, 0, 1'b1, 1'b1, 0, 1'b0,
                     4'hF, 30'h2, 1'b1, 32'h0, 1'b1, 2);

        reset_n = 1'b0;
        core_read_in = 1'b0; core_write_in = 1'b0; core_write_mask_in = 4'h0;
        core_address_in = 32'h0; core_write_value_in = 32'h0; pipe_stall_in = 1'b0;
        bus_dat_in = 32'h0; bus_ack_in = 1'b0; bus_err_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cyc", 32'(bus_cyc_out), 32'd0);
        chk("rst_stb", 32'(bus_stb_out), 32'd0);
        chk("rst_sel", 32'(bus_sel_out), 32'd0);
        chk("rst_adr", 32'(bus_adr_out), 32'd0);
        chk("rst_rdata", core_read_value_out, 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i]);
            if (!vecs[i].chain) begin
                core_read_in  = 1'b0;
                core_write_in = 1'b0;
                #1;
                chk("idle_rdata", core_read_value_out, 32'd0);
                chk("idle_cyc", 32'(bus_cyc_out), 32'd0);
                chk("idle_fault", 32'(fault_out), 32'd0);
                @(negedge clk);
            end
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // Watchdog: no ack ever arrives, TIMEOUT_CYCLES = 4 instance must give up.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        core_read_in = 1'b1; core_write_in = 1'b0; core_address_in = 32'h0000_0500;
        bus_dat_in = 32'h7777_7777; bus_ack_in = 1'b0; bus_err_in = 1'b0;
        busy = 0;
        fin  = 0;
        for (int c = 0; c < 20 && !fin; c++) begin
            #1;
            if (to_cyc) begin
                busy++;
            end else if (busy > 0) begin
                fin = 1;
                chk("to_busy_cycles", 32'(busy), 32'd4);
                chk("to_rdata", to_rdata, 32'd0);
                chk("to_fault", 32'(to_fault), 32'd1);
                chk("to_stall", 32'(to_stall), 32'd0);
            end
            @(negedge clk);
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL to_done: got no DONE expected DONE after 4 busy cycles");
        end

        // Reset while BUSY, then a stale ack.
        reset_n = 1'b0;
        core_read_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        core_read_in = 1'b1; core_address_in = 32'h1234_5678;
        @(negedge clk);
        #1;
        chk("rb_cyc_before", 32'(bus_cyc_out), 32'd1);
        reset_n = 1'b0;
        core_read_in = 1'b0;
        @(negedge clk);
        #1;
        chk("rb_cyc_after", 32'(bus_cyc_out), 32'd0);
        chk("rb_stb_after", 32'(bus_stb_out), 32'd0);
        reset_n = 1'b1;
        bus_ack_in = 1'b1;
        bus_dat_in = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        bus_ack_in = 1'b0;
        chk("rb_cyc", 32'(bus_cyc_out), 32'd0);
        chk("rb_stb", 32'(bus_stb_out), 32'd0);
        chk("rb_we", 32'(bus_we_out), 32'd0);
        chk("rb_sel", 32'(bus_sel_out), 32'd0);
        chk("rb_adr", 32'(bus_adr_out), 32'd0);
        chk("rb_dat", bus_dat_out, 32'd0);
        chk("rb_rdata", core_read_value_out, 32'd0);
        chk("rb_fault", 32'(fault_out), 32'd0);
        chk("rb_stall", 32'(stall_out), 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
